// File: rtl/cache_pkg.sv
// Shared cache line geometry and serializer state type. The line deserializer
// imports this same package so both sides agree on word order and line width.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/line_serializer_if.sv
// Line-in / word-out bus of the line serializer. The master modport is the
// upstream cache side that offers lines and sinks words; slave is the serializer.
interface line_serializer_if #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int WORDS  = cache_pkg::WORDS_PER_LINE
);

    logic [WORD_W*WORDS-1:0]   line_in;
    logic                      line_valid;
    logic                      line_ready;
    logic [WORD_W-1:0]         word_out;
    logic [$clog2(WORDS)-1:0]  word_idx;
    logic                      word_valid;
    logic                      word_ready;
    logic                      word_last;
    logic                      busy;

    modport master (
        output line_in, line_valid, word_ready,
        input  line_ready, word_out, word_idx, word_valid, word_last, busy
    );

    modport slave (
        input  line_in, line_valid, word_ready,
        output line_ready, word_out, word_idx, word_valid, word_last, busy
    );

endinterface

// File: rtl/line_serializer.sv
// Splits one cache line into WORDS words, word k taken from bits
// [k*WORD_W +: WORD_W], so the deserializer reassembles the line bit-exact.
// A new line can be loaded on the last beat of the current one (no bubble).
module line_serializer #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int WORDS  = cache_pkg::WORDS_PER_LINE
) (
    input logic              clk,
    input logic              rst,
    line_serializer_if.slave bus
);

    import cache_pkg::*;

    localparam int                 IW       = $clog2(WORDS);
    localparam logic [IW-1:0]      LAST_IDX = IW'(WORDS - 1);

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [WORD_W*WORDS-1:0] line_q;
    logic                    word_valid_q;
    logic                    word_last_q;

    logic beat;
    logic last_beat;
    logic line_take;

    assign beat      = word_valid_q && bus.word_ready;
    assign last_beat = beat && (idx_q == LAST_IDX);
    assign idx_d     = idx_q + 1'b1;

    // Ready in IDLE, or on the final beat when another line is waiting.
    assign bus.line_ready = (state_q == IDLE) || (last_beat && bus.line_valid);
    assign line_take      = bus.line_valid && bus.line_ready;

    // Outputs decode only registered state; word mux is a part-select of the line.
    assign bus.word_out   = line_q[idx_q*WORD_W +: WORD_W];
    assign bus.word_idx   = idx_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_last  = word_last_q;
    assign bus.busy       = (state_q == SEND);

    // Serializer FSM: load a line, step idx on each beat, reload or idle at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            line_q       <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_take) begin
                        line_q       <= bus.line_in;
                        idx_q        <= '0;
                        word_valid_q <= 1'b1;
                        word_last_q  <= (LAST_IDX == '0);
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (idx_q == LAST_IDX) begin
                            if (line_take) begin
                                line_q       <= bus.line_in;
                                idx_q        <= '0;
                                word_valid_q <= 1'b1;
                                word_last_q  <= (LAST_IDX == '0);
                            end else begin
                                word_valid_q <= 1'b0;
                                word_last_q  <= 1'b0;
                                state_q      <= IDLE;
                            end
                        end else begin
                            idx_q       <= idx_d;
                            word_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    word_valid_q <= 1'b0;
                    word_last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_serializer.sv
// Directed bench for line_serializer: single lines with and without stalls,
// back-to-back lines, reset mid-send, and reassembly by word_idx.
module tb_line_serializer;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    line_serializer_if bus ();

    line_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Offer one line from IDLE and collect its 8 beats. line_in is scrambled
    // every cycle after the handshake; words are reassembled by word_idx.
    task automatic send_one(input string tag, input logic [255:0] l, input bit stall);
        logic [255:0] rx;
        int k;
        rx = '0;
        k  = 0;
        @(negedge clk);
        bus.line_in    = l;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b0;
        #1 chk({tag, ".lrdy_idle"}, bus.line_ready, 1);
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            @(negedge clk);
            bus.line_valid = 1'b0;
            bus.line_in    = rand_line();
            bus.word_ready = stall ? (cyc % 3 == 0) : 1'b1;
            #1;
            chk({tag, ".valid"}, bus.word_valid, 1);
            chk({tag, ".idx"},   bus.word_idx, k);
            chk({tag, ".word"},  bus.word_out, l[k*32 +: 32]);
            chk({tag, ".last"},  bus.word_last, (k == 7));
            chk({tag, ".lrdy"},  bus.line_ready, 0);
            chk({tag, ".busy"},  bus.busy, 1);
            if (bus.word_ready) begin
                rx[bus.word_idx*32 +: 32] = bus.word_out;
                k++;
            end
        end
        chk({tag, ".beats"}, k, 8);
        chk({tag, ".reasm"}, rx, l);
        @(negedge clk);
        #1;
        chk({tag, ".end_valid"}, bus.word_valid, 0);
        chk({tag, ".end_lrdy"},  bus.line_ready, 1);
        chk({tag, ".end_busy"},  bus.busy, 0);
        chk({tag, ".end_last"},  bus.word_last, 0);
    endtask

    initial begin
        logic [255:0] la, lb, lc, lk;
        int k;

        for (int i = 0; i < 8; i++) begin
            lk[i*32 +: 32] = i;
            la[i*32 +: 32] = 32'hA000_0000 | i;
            lb[i*32 +: 32] = 32'hB000_0000 | i;
            lc[i*32 +: 32] = 32'hC000_0000 | i;
        end

        // Reset state, with a line offered during reset
        rst            = 1'b1;
        bus.line_in    = la;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.valid", bus.word_valid, 0);
        chk("rst.lrdy",  bus.line_ready, 1);
        chk("rst.last",  bus.word_last, 0);
        chk("rst.idx",   bus.word_idx, 0);
        chk("rst.busy",  bus.busy, 0);
        chk("rst.word",  bus.word_out, 0);
        bus.line_valid = 1'b0;
        rst            = 1'b0;

        send_one("seq",   lk, 1'b0);
        send_one("stall", lk, 1'b1);

        // Back-to-back A then B with continuous word_ready
        @(negedge clk);
        bus.line_in    = la;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b1;
        #1 chk("b2b.lrdy_idle", bus.line_ready, 1);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
            @(negedge clk);
            bus.word_ready = 1'b1;
            if (k == 7) begin
                bus.line_in    = lb;
                bus.line_valid = 1'b1;
            end else begin
                bus.line_in    = rand_line();
                bus.line_valid = 1'b0;
            end
            #1;
            chk("b2b.valid", bus.word_valid, 1);
            chk("b2b.idx",   bus.word_idx, k % 8);
            chk("b2b.word",  bus.word_out, (k < 8) ? la[k*32 +: 32] : lb[(k-8)*32 +: 32]);
            chk("b2b.last",  bus.word_last, (k % 8 == 7));
            chk("b2b.lrdy",  bus.line_ready, (k == 7));
            k++;
        end
        chk("b2b.beats", k, 16);
        bus.line_valid = 1'b0;
        @(negedge clk);
        #1 chk("b2b.end_valid", bus.word_valid, 0);

        // Reset after beat 3; reset beats a simultaneously offered line
        @(negedge clk);
        bus.line_in    = la;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.line_valid = 1'b0;
            bus.word_ready = 1'b1;
            #1 chk("mid.word", bus.word_out, la[i*32 +: 32]);
        end
        @(negedge clk);
        #1 chk("mid.idx4", bus.word_idx, 4);
        rst            = 1'b1;
        bus.line_in    = lc;
        bus.line_valid = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.line_valid = 1'b0;
        #1;
        chk("mid.valid", bus.word_valid, 0);
        chk("mid.busy",  bus.busy, 0);
        chk("mid.idx",   bus.word_idx, 0);
        chk("mid.lrdy",  bus.line_ready, 1);
        chk("mid.word0", bus.word_out, 0);
        @(negedge clk);
        #1 chk("mid.notaken", bus.word_valid, 0);
        send_one("after_rst", lc, 1'b0);

        // Random lines through the reassembly path
        send_one("loop0", rand_line(), 1'b0);
        send_one("loop1", rand_line(), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
